// File: rtl/pe_pkg.sv
// Shared widths and types for the MAC processing element.
// The PE_ACC_CLR_EN macro (accumulator restart input) is honoured by mac_pe_if and mac_pe.
package pe_pkg;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    typedef logic [DATA_W-1:0] operand_t;
    typedef logic [ACC_W-1:0]  acc_t;
endpackage : pe_pkg

// File: rtl/mac_pe_if.sv
// Operand/result bundle for mac_pe; the master drives operands and the slave returns the sum.
// With PE_ACC_CLR_EN defined the bundle also carries the clr restart strobe.
interface mac_pe_if #(
    parameter int DATA_W = pe_pkg::DATA_W,
    parameter int ACC_W  = pe_pkg::ACC_W
);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ACC_W-1:0]  c;
`ifdef PE_ACC_CLR_EN
    logic              clr;

    modport master (output a, output b, output clr, input c);
    modport slave  (input a, input b, input clr, output c);
`else
    modport master (output a, output b, input c);
    modport slave  (input a, input b, output c);
`endif
endinterface : mac_pe_if

// File: rtl/pe_mult.sv
// Registered unsigned multiplier stage: the full-width product is zero-extended
// to the accumulator width and cleared by the active-low synchronous reset.
module pe_mult #(
    parameter int DATA_W = pe_pkg::DATA_W,
    parameter int ACC_W  = pe_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_prod
);
    logic [2*DATA_W-1:0] w_full;
    logic [ACC_W-1:0]    r_prod;

    // Widen before multiplying so the full 2*DATA_W product is kept.
    assign w_full = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prod <= '0;
        end else begin
            r_prod <= ACC_W'(w_full);
        end
    end

    assign o_prod = r_prod;
endmodule : pe_mult

// File: rtl/mac_pe.sv
// Two-stage multiply-accumulate element: product register, then a wrapping accumulator.
// Optional PE_ACC_CLR_EN adds clr, which restarts the sum from the pipelined product.
module mac_pe
    import pe_pkg::*;
#(
    parameter int DATA_W = pe_pkg::DATA_W,
    parameter int ACC_W  = pe_pkg::ACC_W
) (
    input  logic     clk,
    input  logic     rst,
    mac_pe_if.slave  bus
);
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] r_acc;

    pe_mult #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .clk    (clk),
        .rst    (rst),
        .i_a    (bus.a),
        .i_b    (bus.b),
        .o_prod (w_prod)
    );

    // Accumulation wraps modulo 2^ACC_W by plain truncating addition.
    always_comb begin
        w_acc_next = r_acc + w_prod;
`ifdef PE_ACC_CLR_EN
        if (bus.clr) begin
            w_acc_next = w_prod;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    assign bus.c = r_acc;
endmodule : mac_pe

// File: tb/tb_mac_pe.sv
// Directed-vector bench for mac_pe: reset, MAC pipeline latency, zero operands,
// wrap-around, mid-run reset and, when PE_ACC_CLR_EN is defined, the clr restart.
module tb_mac_pe;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic r, input operand_t a, input operand_t b, input logic cl);
        rst   = r;
        bus.a = a;
        bus.b = b;
`ifdef PE_ACC_CLR_EN
        bus.clr = cl;
`else
        if (cl) $display("note: clr requested but feature not built");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input acc_t exp);
        n_vec++;
        assert (bus.c === exp) else begin
            n_err++;
            $error("FAIL %s: c=%0d expected %0d", tag, bus.c, exp);
        end
        $display("vec %0d %s: c=%0d expected %0d", n_vec, tag, bus.c, exp);
    endtask

    initial begin
        rst   = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef PE_ACC_CLR_EN
        bus.clr = 1'b0;
`endif

        // Reset held for two edges with nonzero operands.
        step(1'b0, 16'd5, 16'd7, 1'b0);    check("rst_edge1", 32'd0);
        step(1'b0, 16'd5, 16'd7, 1'b0);    check("rst_edge2", 32'd0);

        // Basic MAC sequence.
        step(1'b1, 16'd10, 16'd20, 1'b0);  check("mac_e1", 32'd0);
        step(1'b1, 16'd10, 16'd20, 1'b0);  check("mac_e2", 32'd200);
        step(1'b1, 16'd30, 16'd40, 1'b0);  check("mac_e3", 32'd400);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("mac_e4", 32'd1600);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("mac_hold", 32'd1600);

        // Single operand pair: shows up exactly one edge after sampling.
        step(1'b1, 16'd30, 16'd40, 1'b0);  check("single_sample", 32'd1600);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("single_add", 32'd2800);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("single_hold", 32'd2800);

        // One zero operand contributes nothing.
        step(1'b1, 16'd0,   16'd999, 1'b0); check("zero_a_e1", 32'd2800);
        step(1'b1, 16'd999, 16'd0,   1'b0); check("zero_a_e2", 32'd2800);
        step(1'b1, 16'd0,   16'd0,   1'b0); check("zero_b", 32'd2800);

        // Reset mid-operation with live operands; first edge after release adds 0.
        step(1'b1, 16'd10, 16'd20, 1'b0);  check("pre_rst", 32'd2800);
        step(1'b0, 16'd10, 16'd20, 1'b0);  check("mid_rst", 32'd0);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("post_rst_adds0", 32'd0);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("post_rst_hold", 32'd0);

        // Wrap-around with maximal operands.
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0); check("wrap_e1", 32'd0);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0); check("wrap_e2", 32'd4294836225);
        step(1'b1, 16'd0,    16'd0,    1'b0); check("wrap_e3", 32'd4294705154);
        step(1'b1, 16'd0,    16'd0,    1'b0); check("wrap_hold", 32'd4294705154);

`ifdef PE_ACC_CLR_EN
        // Build c=1400 with prod=200 pending, then restart with clr.
        step(1'b0, 16'd0,  16'd0,  1'b0);  check("clr_setup_rst", 32'd0);
        step(1'b1, 16'd30, 16'd40, 1'b0);  check("clr_setup1", 32'd0);
        step(1'b1, 16'd10, 16'd20, 1'b0);  check("clr_setup2", 32'd1200);
        step(1'b1, 16'd10, 16'd20, 1'b0);  check("clr_setup3", 32'd1400);
        step(1'b1, 16'd3,  16'd4,  1'b1);  check("clr_restart", 32'd200);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("clr_resume", 32'd212);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("clr_hold", 32'd212);
        step(1'b0, 16'd5,  16'd5,  1'b1);  check("rst_over_clr", 32'd0);
        step(1'b1, 16'd0,  16'd0,  1'b0);  check("rst_over_clr_prod", 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_mac_pe

// File: doc/mac_pe.md
Name: mac_pe

Overview:
- Single multiply-accumulate processing element for systolic/array datapaths.
- Each cycle it multiplies two unsigned operands and adds the product into a running accumulator.
- The running sum is exposed on `c`.
- Two-stage pipeline: a product register, then an accumulator register.

Parameters:
- DATA_W, 16, width of operands a and b.
- ACC_W, 32, width of product/accumulator and output c; must be >= 2*DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- a  input  DATA_W  unsigned multiplicand, sampled every rising edge.
- b  input  DATA_W  unsigned multiplier, sampled every rising edge.
- c  output  ACC_W  accumulated sum, registered.
- clr  input  1  present only with PE_ACC_CLR_EN; see Optional Feature.

Behaviour:
- Reset:
  - On a rising edge with rst==0, the product register and accumulator c both clear to 0.
  - Reset overrides all other activity, including a reset asserted mid-accumulation.
- Stage 1, at every non-reset edge:
  - prod <= a*b, unsigned, full 2*DATA_W result zero-extended to ACC_W.
- Stage 2, at the same edge:
  - c <= c + prod, using the prod value from the previous cycle.
- Latency:
  - Operands present at edge N are added into c at edge N+1.
  - They are visible on c after edge N+1.
  - First edge after reset release adds 0 to c, because prod was cleared.
- Throughput: one MAC per cycle; no handshake, no stall, no enable; a and b are consumed every cycle.
- Overflow: the accumulator wraps modulo 2^ACC_W; no saturation, no overflow flag.
- Zero operands: a or b equal to 0 contributes 0, and c holds its value.
- No combinational path from a or b to c.
- No X propagation after reset: all registers are reset.

Optional Feature:
- Macro: PE_ACC_CLR_EN.
- Defined:
  - Adds input clr (1 bit, active-high, synchronous).
  - When clr==1 and rst==1 at an edge: c <= prod, so the accumulation restarts with the pipelined product.
  - prod still captures a*b on that edge.
  - rst has priority over clr.
- Undefined:
  - No clr port.
  - The accumulator is cleared only by rst.

Decomposition:
- Shared package pe_pkg:
  - constants DATA_W=16 and ACC_W=32.
  - typedefs operand_t (logic [DATA_W-1:0]) and acc_t (logic [ACC_W-1:0]).
- Optional sub-module pe_mult: registered unsigned multiplier stage (a, b -> prod).
- Accumulator remains in mac_pe.

Test Plan:
- Reset: hold rst=0 for 2 edges with a=5, b=7 -> c==0 after each edge.
- Basic MAC sequence:
  - Release rst; then, before each edge: a=10/b=20 for the first two edges, a=30/b=40 for the third.
  - Required: c==0 after the 1st edge, 200 after the 2nd, 400 after the 3rd.
  - Required: c==1600 after the 4th edge, with a=b=0 from the 4th edge on.
- Single-operand pipeline check: a=30, b=40 for one cycle, then a=b=0 -> c increments by exactly 1200 one edge after sampling, then holds constant.
- Wrap-around:
  - Drive a=b=65535 (product 4294836225) for 2 consecutive cycles, then a=b=0.
  - Required: c==4294836225, then (2*4294836225) mod 2^32 = 4294705154.
- Reset mid-operation: accumulate to a nonzero c, pull rst=0 for one edge -> c==0 and prod cleared; after release, the next edge adds 0.
- With PE_ACC_CLR_EN:
  - Setup: c=1400, pending prod=200 (a=10, b=20 sampled the previous edge).
  - Stimulus: assert clr for one edge.
  - Required: c==200, after which accumulation resumes normally.
